srt_div_result_packer: RTL

- Back end of the SRT single-precision divider, opposite end of the front-end operand normalizer.
- Takes the raw SRT quotient mantissa, the biased exponent, the operand normalization shift counts and the result sign.
- Renormalizes the quotient, denormalizes it serially when the result underflows, rounds to nearest-even and packs an IEEE-754 single.
- Valid/ready on both sides; one operation in flight.

---
 rtl/srt_div_result_packer_if.sv | 40 ++++
 rtl/srt_div_result_packer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/srt_div_result_packer_if.sv
// Request/response bundle between the SRT divider core, the result packer and the
// consumer of packed single-precision results.
interface srt_div_result_packer_if #(
    parameter int unsigned QW = 26
);
    // Operation request from the divider core
    logic          in_valid;
    logic          in_ready;
    logic [QW-1:0] quotient;
    logic          sticky_in;
    logic [7:0]    exp_in;
    logic [4:0]    dividend_shift;
    logic [4:0]    divisor_shift;
    logic          result_sign;
    logic          in_nan;
    logic          in_inf;
    logic          in_zero;

    // Packed result towards the consumer
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   result;
    logic          overflow;
    logic          underflow;
    logic          inexact;

    // Packer side
    modport slave (
        input  in_valid, quotient, sticky_in, exp_in, dividend_shift, divisor_shift,
               result_sign, in_nan, in_inf, in_zero, out_ready,
        output in_ready, out_valid, result, overflow, underflow, inexact
    );

    // Producer/consumer side
    modport master (
        output in_valid, quotient, sticky_in, exp_in, dividend_shift, divisor_shift,
               result_sign, in_nan, in_inf, in_zero, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, inexact
    );
endinterface

// File: rtl/srt_div_result_packer.sv
// Back end of the SRT single-precision divider: renormalizes the raw quotient,
// denormalizes serially on underflow, rounds to nearest-even and packs an IEEE-754
// single. One operation in flight; the result is held until the consumer takes it.
module srt_div_result_packer #(
    parameter int unsigned QW         = 26,
    parameter int unsigned MAX_DSHIFT = 26
) (
    input logic                    clk,
    input logic                    rst,
    srt_div_result_packer_if.slave bus
);
    localparam int unsigned     CntW   = $clog2(MAX_DSHIFT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_DSHIFT);

    typedef enum logic [2:0] {StIdle, StNorm, StDenorm, StRound, StHold} state_e;

    state_e            state_q, state_d;
    logic [QW-1:0]     q_q, q_d;
    logic              sticky_q, sticky_d;
    logic signed [9:0] e_q, e_d;
    logic              sign_q, sign_d;
    logic              denorm_q, denorm_d;
    logic [CntW-1:0]   dcnt_q, dcnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              inx_q, inx_d;

    logic [23:0]       mant;
    logic              guard, rnd, round_up, rnd_inexact;
    logic [24:0]       mant_r;
    logic signed [9:0] e_r;

    // Round-to-nearest-even on the held quotient; only consumed in ROUND.
    always_comb begin
        mant        = q_q[QW-1:2];
        guard       = q_q[1];
        rnd         = q_q[0];
        round_up    = guard & (rnd | sticky_q | mant[0]);
        rnd_inexact = guard | rnd | sticky_q;
        mant_r      = {1'b0, mant} + {24'd0, round_up};
        e_r         = mant_r[24] ? e_q + 10'sd1 : e_q;
    end

    // Next-state, datapath and packed-result logic.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        sticky_d = sticky_q;
        e_d      = e_q;
        sign_d   = sign_q;
        denorm_d = denorm_q;
        dcnt_d   = dcnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    q_d      = bus.quotient;
                    sticky_d = bus.sticky_in;
                    sign_d   = bus.result_sign;
                    e_d      = $signed({2'b00, bus.exp_in} - {5'd0, bus.dividend_shift}
                                       + {5'd0, bus.divisor_shift});
                    denorm_d = 1'b0;
                    dcnt_d   = '0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inx_d    = 1'b0;
                    if (bus.in_nan) begin
                        result_d = 32'h7FC0_0000;
                        state_d  = StHold;
                    end else if (bus.in_inf) begin
                        result_d = {bus.result_sign, 8'hFF, 23'd0};
                        state_d  = StHold;
                    end else if (bus.in_zero) begin
                        result_d = {bus.result_sign, 31'd0};
                        state_d  = StHold;
                    end else begin
                        state_d = StNorm;
                    end
                end
            end
            StNorm: begin
                if (q_q == '0) begin
                    result_d = {sign_q, 31'd0};
                    state_d  = StHold;
                end else begin
                    // Quotient lies in [0.5,2), so one left shift always normalizes.
                    if (!q_q[QW-1]) begin
                        q_d = q_q << 1;
                        e_d = e_q - 10'sd1;
                    end
                    if (e_d >= 10'sd255) begin
                        result_d = {sign_q, 8'hFF, 23'd0};
                        ovf_d    = 1'b1;
                        inx_d    = 1'b1;
                        state_d  = StHold;
                    end else if (e_d <= 10'sd0) begin
                        state_d = StDenorm;
                    end else begin
                        state_d = StRound;
                    end
                end
            end
            StDenorm: begin
                q_d      = q_q >> 1;
                sticky_d = sticky_q | q_q[0];
                e_d      = e_q + 10'sd1;
                dcnt_d   = dcnt_q + 1'b1;
                if (e_d == 10'sd1) begin
                    denorm_d = 1'b1;
                    state_d  = StRound;
                end else if (dcnt_d == MaxCnt) begin
                    // Everything has fallen below the round bit: collapse into sticky.
                    q_d      = '0;
                    sticky_d = sticky_q | (q_q != '0);
                    denorm_d = 1'b1;
                    state_d  = StRound;
                end
            end
            StRound: begin
                inx_d = rnd_inexact;
                ovf_d = 1'b0;
                unf_d = denorm_q & rnd_inexact;
                if (denorm_q) begin
                    // A denormal rounding up into bit 23 becomes the smallest normal.
                    result_d = {sign_q, 7'd0, mant_r[23], mant_r[22:0]};
                end else if (mant_r[24]) begin
                    result_d = {sign_q, e_r[7:0], 23'd0};
                    ovf_d    = (e_r == 10'sd255);
                end else begin
                    result_d = {sign_q, e_q[7:0], mant_r[22:0]};
                end
                state_d = StHold;
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StHold);
    end

    // State and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            q_q         <= '0;
            sticky_q    <= 1'b0;
            e_q         <= '0;
            sign_q      <= 1'b0;
            denorm_q    <= 1'b0;
            dcnt_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            sticky_q    <= sticky_d;
            e_q         <= e_d;
            sign_q      <= sign_d;
            denorm_q    <= denorm_d;
            dcnt_q      <= dcnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.inexact   = inx_q;
endmodule
